// File: rtl/rally_scorer.sv
// rally_scorer
//   Sits downstream of slow_ball. Watches the ball LED position and rally hit
//   count, detects a missed ball, awards the point, keeps tennis (default) or
//   squash PAR-11 score, and asks slow_ball for the next serve.
//
//   Build option: define SQUASH_SCORING_EN to replace tennis scoring with
//   squash PAR-11 (plain counts, win by 2 from 11, server = last winner).
//
// Parameters
//   GAP_CYCLES    pause between point award and next serve (>= 1)
//   GAMES_TO_WIN  games needed to win the match (1..15)
//
// Ports
//   clock, reset       posedge clock, synchronous active-high reset
//   start              level, starts a match from IDLE only
//   light[15:0]        one-hot ball position, bit15 = left end, 0 = ball out
//   hitnum[2:0]        rally hit count
//   serve[1:0]         01 left serves, 10 right serves, 00 none
//   left_pts/right_pts point score (tennis code 0..4 or squash count)
//   left_games/right_games  games won (saturate at 15)
//   point_pulse        one cycle on point award
//   point_winner       0 = left, 1 = right; held until the next award
//   max_rally          largest hitnum seen at any award this match
//   match_over         high once the match is decided
module rally_scorer #(
  parameter int unsigned GAP_CYCLES   = 50_000_000,
  parameter int unsigned GAMES_TO_WIN = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] light,
  input  logic [2:0]  hitnum,
  output logic [1:0]  serve,
  output logic [4:0]  left_pts,
  output logic [4:0]  right_pts,
  output logic [3:0]  left_games,
  output logic [3:0]  right_games,
  output logic        point_pulse,
  output logic        point_winner,
  output logic [2:0]  max_rally,
  output logic        match_over
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [3:0]    GAMES_W  = 4'(GAMES_TO_WIN);

  typedef enum logic [2:0] {
    S_IDLE, S_SERVE, S_RALLY, S_POINT, S_GAP, S_DONE
  } state_t;

  typedef enum logic [1:0] { E_NONE, E_L, E_R } edge_t;

  state_t        state_q, state_d;
  edge_t         edge_q, edge_d;
  logic          server_q, server_d;   // 0 = left, 1 = right
  logic          winner_q, winner_d;
  logic [4:0]    lpts_q, lpts_d, rpts_q, rpts_d;
  logic [3:0]    lgames_q, lgames_d, rgames_q, rgames_d;
  logic [2:0]    max_q, max_d;
  logic [GW-1:0] gap_q, gap_d;

  // Score arithmetic is done in winner/loser terms, then mapped back.
  logic [4:0] w_pts, l_pts, nw_pts, nl_pts;
  logic       game_won;

  always_comb begin
    w_pts    = winner_q ? rpts_q : lpts_q;
    l_pts    = winner_q ? lpts_q : rpts_q;
    nw_pts   = w_pts;
    nl_pts   = l_pts;
    game_won = 1'b0;
`ifdef SQUASH_SCORING_EN
    nw_pts = w_pts + 5'd1;
    if (nw_pts >= 5'd11 && nw_pts >= l_pts + 5'd2) begin
      game_won = 1'b1;
    end else if (nw_pts == 5'd11 && l_pts == 5'd11) begin
      // 11-11 folds back to 10-10 so the counts stay bounded.
      nw_pts = 5'd10;
      nl_pts = 5'd10;
    end
`else
    if (w_pts == 5'd4) begin
      game_won = 1'b1;
    end else if (w_pts == 5'd3) begin
      if (l_pts < 5'd3) begin
        game_won = 1'b1;
      end else if (l_pts == 5'd3) begin
        nw_pts = 5'd4;                // advantage
      end else begin
        nw_pts = 5'd3;                // loser had advantage: back to deuce
        nl_pts = 5'd3;
      end
    end else begin
      nw_pts = w_pts + 5'd1;
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    edge_d   = edge_q;
    server_d = server_q;
    winner_d = winner_q;
    lpts_d   = lpts_q;
    rpts_d   = rpts_q;
    lgames_d = lgames_q;
    rgames_d = rgames_q;
    max_d    = max_q;
    gap_d    = gap_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_SERVE;
      end
      S_SERVE: begin
        edge_d  = E_NONE;
        state_d = S_RALLY;
      end
      S_RALLY: begin
        if (light == 16'h8000) begin
          edge_d = E_L;
        end else if (light == 16'h0001) begin
          edge_d = E_R;
        end else if (light == 16'h0000) begin
          // Ball out past the last end it touched; out before any end
          // touch means it has not been launched yet.
          if (edge_q == E_L) begin
            winner_d = 1'b1;
            state_d  = S_POINT;
          end else if (edge_q == E_R) begin
            winner_d = 1'b0;
            state_d  = S_POINT;
          end
        end
      end
      S_POINT: begin
        if (hitnum > max_q) max_d = hitnum;
        gap_d   = '0;
        state_d = S_GAP;
        if (game_won) begin
          lpts_d = '0;
          rpts_d = '0;
          if (winner_q) begin
            if (rgames_q != 4'hF) rgames_d = rgames_q + 4'd1;
          end else begin
            if (lgames_q != 4'hF) lgames_d = lgames_q + 4'd1;
          end
`ifndef SQUASH_SCORING_EN
          server_d = ~server_q;
`endif
        end else begin
          lpts_d = winner_q ? nl_pts : nw_pts;
          rpts_d = winner_q ? nw_pts : nl_pts;
        end
`ifdef SQUASH_SCORING_EN
        server_d = winner_q;
`endif
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          if (lgames_q == GAMES_W || rgames_q == GAMES_W) state_d = S_DONE;
          else                                            state_d = S_SERVE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      edge_q   <= E_NONE;
      server_q <= 1'b0;
      winner_q <= 1'b0;
      lpts_q   <= '0;
      rpts_q   <= '0;
      lgames_q <= '0;
      rgames_q <= '0;
      max_q    <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      edge_q   <= edge_d;
      server_q <= server_d;
      winner_q <= winner_d;
      lpts_q   <= lpts_d;
      rpts_q   <= rpts_d;
      lgames_q <= lgames_d;
      rgames_q <= rgames_d;
      max_q    <= max_d;
      gap_q    <= gap_d;
    end
  end

  assign serve        = (state_q == S_SERVE) ? (server_q ? 2'b10 : 2'b01) : 2'b00;
  assign point_pulse  = (state_q == S_POINT);
  assign point_winner = winner_q;
  assign left_pts     = lpts_q;
  assign right_pts    = rpts_q;
  assign left_games   = lgames_q;
  assign right_games  = rgames_q;
  assign max_rally    = max_q;
  assign match_over   = (state_q == S_DONE);

endmodule

// File: tb/tb_rally_scorer.sv
module tb_rally_scorer;
  localparam int GAP = 4;

  logic        clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic [15:0] light = '0;
  logic [2:0]  hitnum = '0;

  logic [1:0] serve, serve1;
  logic [4:0] left_pts, right_pts, left_pts1, right_pts1;
  logic [3:0] left_games, right_games, left_games1, right_games1;
  logic       point_pulse, point_winner, point_pulse1, point_winner1;
  logic [2:0] max_rally, max_rally1;
  logic       match_over, match_over1;

  rally_scorer #(.GAP_CYCLES(GAP), .GAMES_TO_WIN(6)) dut (
    .clock(clock), .reset(reset), .start(start), .light(light), .hitnum(hitnum),
    .serve(serve), .left_pts(left_pts), .right_pts(right_pts),
    .left_games(left_games), .right_games(right_games),
    .point_pulse(point_pulse), .point_winner(point_winner),
    .max_rally(max_rally), .match_over(match_over));

  // One-game match, fed the same stimulus; only checked after a reset.
  rally_scorer #(.GAP_CYCLES(GAP), .GAMES_TO_WIN(1)) dut1 (
    .clock(clock), .reset(reset), .start(start), .light(light), .hitnum(hitnum),
    .serve(serve1), .left_pts(left_pts1), .right_pts(right_pts1),
    .left_games(left_games1), .right_games(right_games1),
    .point_pulse(point_pulse1), .point_winner(point_winner1),
    .max_rally(max_rally1), .match_over(match_over1));

  always #5 clock = ~clock;

  int total = 0, bad = 0;

  // Reference model: raw point counts per game, converted to display codes.
  int ma, mb, mlg, mrg, mmax;
  bit mserver, mwin;

  task automatic model_reset();
    ma = 0; mb = 0; mlg = 0; mrg = 0; mmax = 0; mserver = 0; mwin = 0;
  endtask

  task automatic model_point(input bit rwin, input int hn);
    bit gl, gr;
    if (rwin) mb++; else ma++;
    mwin = rwin;
    if (hn > mmax) mmax = hn;
`ifdef SQUASH_SCORING_EN
    gl = (ma >= 11) && (ma - mb >= 2);
    gr = (mb >= 11) && (mb - ma >= 2);
    if (!gl && !gr && ma == 11 && mb == 11) begin ma = 10; mb = 10; end
    mserver = rwin;
`else
    gl = (ma >= 4) && (ma - mb >= 2);
    gr = (mb >= 4) && (mb - ma >= 2);
    if (gl || gr) mserver = ~mserver;
`endif
    if (gl && mlg < 15) mlg++;
    if (gr && mrg < 15) mrg++;
    if (gl || gr) begin ma = 0; mb = 0; end
  endtask

  task automatic exp_codes(output int el, output int er);
`ifdef SQUASH_SCORING_EN
    el = ma; er = mb;
`else
    if (ma >= 3 && mb >= 3) begin
      if (ma == mb)     begin el = 3; er = 3; end
      else if (ma > mb) begin el = 4; er = 3; end
      else              begin el = 3; er = 4; end
    end else begin
      el = ma; er = mb;
    end
`endif
  endtask

  task automatic step(input logic [15:0] v);
    light = v;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; light = '0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic begin_match();
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
  endtask

  // Plays one rally that the given side wins, checking the award and score.
  task automatic play_point(input bit rwin, input logic [2:0] hn, input int pre0, output bit ok);
    int el, er, n;
    logic [1:0]  es;
    logic [15:0] fin, oth, mid;
    ok = 1'b1;
    hitnum = hn;
    for (int i = 0; i < 40 && serve === 2'b00; i++) @(negedge clock);
    es = mserver ? 2'b10 : 2'b01;
    total++;
    if (serve !== es) begin
      $display("FAIL serve_code got=%b exp=%b", serve, es); bad++;
      if (serve === 2'b00) begin ok = 1'b0; return; end
    end
    fin = rwin ? 16'h8000 : 16'h0001;
    oth = rwin ? 16'h0001 : 16'h8000;
    exp_codes(el, er);
    step(16'h0000);
    total++;
    if (serve !== 2'b00) begin $display("FAIL serve_one_cycle got=%b exp=00", serve); bad++; end
    for (int i = 0; i < pre0; i++) begin
      step(16'h0000);
      total++;
      if (point_pulse !== 1'b0 || left_pts !== 5'(el) || right_pts !== 5'(er)) begin
        $display("FAIL no_launch pulse=%b pts=%0d/%0d exp=0 %0d/%0d", point_pulse, left_pts, right_pts, el, er);
        bad++;
      end
    end
    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin
      mid = 16'h0001;
      mid = mid << $urandom_range(1, 14);
      step(mid);
      if ($urandom_range(0, 1) == 1) step(oth);
    end
    step(fin);
    total++;
    if (point_pulse !== 1'b0) begin $display("FAIL early_pulse got=%b exp=0", point_pulse); bad++; end
    step(16'h0000);
    total++;
    if (point_pulse !== 1'b1 || point_winner !== rwin) begin
      $display("FAIL award pulse=%b winner=%b exp=1 %b", point_pulse, point_winner, rwin); bad++;
    end
    model_point(rwin, int'(hn));
    exp_codes(el, er);
    step(16'h0000);
    total++;
    if (left_pts !== 5'(el) || right_pts !== 5'(er)) begin
      $display("FAIL pts got=%0d/%0d exp=%0d/%0d", left_pts, right_pts, el, er); bad++;
    end
    total++;
    if (left_games !== 4'(mlg) || right_games !== 4'(mrg)) begin
      $display("FAIL games got=%0d/%0d exp=%0d/%0d", left_games, right_games, mlg, mrg); bad++;
    end
    total++;
    if (max_rally !== 3'(mmax) || point_pulse !== 1'b0 || point_winner !== mwin) begin
      $display("FAIL post_point max=%0d pulse=%b win=%b exp=%0d 0 %b", max_rally, point_pulse, point_winner, mmax, mwin);
      bad++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; light = '0;
    @(posedge clock);
    @(negedge clock);
    total++;
    if ({serve, left_pts, right_pts, left_games, right_games, point_pulse, point_winner, max_rally, match_over} !== '0) begin
      $display("FAIL reset_outputs got=%h exp=0",
        {serve, left_pts, right_pts, left_games, right_games, point_pulse, point_winner, max_rally, match_over});
      bad++;
    end
    total++;
    if ({serve1, left_pts1, right_pts1, left_games1, right_games1, point_pulse1, point_winner1, max_rally1, match_over1} !== '0) begin
      $display("FAIL reset_outputs1 got=%h exp=0",
        {serve1, left_pts1, right_pts1, left_games1, right_games1, point_pulse1, point_winner1, max_rally1, match_over1});
      bad++;
    end
    reset = 1'b0;
    model_reset();
    step(16'h0001);
    total++;
    if (serve !== 2'b00) begin $display("FAIL idle_no_serve got=%b exp=00", serve); bad++; end
  endtask

  task automatic test_first_point();
    bit ok;
    do_reset();
    begin_match();
    play_point(1'b0, 3'd1, 0, ok);
  endtask

  task automatic test_no_launch();
    bit ok;
    do_reset();
    begin_match();
    play_point(1'b1, 3'd2, 3, ok);
  endtask

  task automatic test_straight_game();
    bit ok;
    do_reset();
    begin_match();
    for (int i = 0; i < 4; i++) play_point(1'b0, 3'($urandom_range(0, 7)), 0, ok);
    play_point(1'b1, 3'd0, 0, ok);
  endtask

  task automatic test_deuce();
    bit ok;
    bit seq [10] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0};
    do_reset();
    begin_match();
    foreach (seq[i]) play_point(seq[i], 3'($urandom_range(0, 7)), 0, ok);
  endtask

  task automatic test_match_over();
    bit ok;
    logic [1:0] es;
    do_reset();
    begin_match();
    for (int i = 0; i < 20 && mlg == 0; i++) play_point(1'b0, 3'd3, 0, ok);
    repeat (GAP - 1) step(16'h0000);
    total++;
    if (match_over1 !== 1'b0) begin $display("FAIL done_early got=%b exp=0", match_over1); bad++; end
    step(16'h0000);
    es = mserver ? 2'b10 : 2'b01;
    total++;
    if (match_over1 !== 1'b1 || left_games1 !== 4'd1 || serve1 !== 2'b00) begin
      $display("FAIL done_entry over=%b games=%0d serve=%b exp=1 1 00", match_over1, left_games1, serve1); bad++;
    end
    total++;
    if (match_over !== 1'b0 || serve !== es) begin
      $display("FAIL six_game_continues over=%b serve=%b exp=0 %b", match_over, serve, es); bad++;
    end
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(16'h0000);
      total++;
      if (match_over1 !== 1'b1 || serve1 !== 2'b00) begin
        $display("FAIL done_sticky over=%b serve=%b exp=1 00", match_over1, serve1); bad++;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_max_and_reset();
    bit ok;
    do_reset();
    begin_match();
    play_point(1'b0, 3'd5, 0, ok);
    play_point(1'b1, 3'd2, 0, ok);
    total++;
    if (max_rally !== 3'd5) begin $display("FAIL max_rally got=%0d exp=5", max_rally); bad++; end
    for (int i = 0; i < 40 && serve === 2'b00; i++) @(negedge clock);
    step(16'h0000);
    step(16'h0100);
    step(16'h8000);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    total++;
    if ({serve, left_pts, right_pts, left_games, right_games, point_pulse, point_winner, max_rally, match_over} !== '0) begin
      $display("FAIL reset_in_rally got=%h exp=0",
        {serve, left_pts, right_pts, left_games, right_games, point_pulse, point_winner, max_rally, match_over});
      bad++;
    end
    reset = 1'b0;
    model_reset();
  endtask

`ifdef SQUASH_SCORING_EN
  task automatic test_squash();
    bit ok;
    bit seq [4] = '{1, 0, 1, 1};
    do_reset();
    begin_match();
    for (int i = 0; i < 10; i++) begin
      play_point(1'b0, 3'd1, 0, ok);
      play_point(1'b1, 3'd1, 0, ok);
    end
    foreach (seq[i]) play_point(seq[i], 3'd4, 0, ok);
    total++;
    if (right_games !== 4'd1 || left_pts !== 5'd0 || right_pts !== 5'd0) begin
      $display("FAIL squash_game games=%0d pts=%0d/%0d exp=1 0/0", right_games, left_pts, right_pts); bad++;
    end
    play_point(1'b0, 3'd0, 0, ok);
  endtask
`endif

  task automatic test_random();
    bit ok;
    do_reset();
    begin_match();
    for (int i = 0; i < 40; i++) begin
      if (mlg == 6 || mrg == 6) break;
      play_point(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom_range(0, 2), ok);
      if (!ok) break;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_point();
    test_no_launch();
    test_straight_game();
    test_deuce();
    test_match_over();
    test_max_and_reset();
`ifdef SQUASH_SCORING_EN
    test_squash();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
